joystick_array: RTL and testbench
=================================

JOYSTICK_ARRAY -- requirements
Module: joystick_array

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of joystick channels (1..8).
REQ-002 SHALL have parameter N_BTN, default 5, buttons per channel in order up, down, left, right, fire.
REQ-003 SHALL have parameter DEB_CYCLES, default 500000, debounce stability window in clk cycles (>=2).
REQ-004 SHALL have parameters REPEAT_DELAY, default 25000000, and REPEAT_PERIOD, default 5000000, in clk cycles.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_btn_n, input, N_CH*N_BTN, raw active-low switches; bit index ch*N_BTN+btn.
REQ-008 SHALL have port o_vdd, output, N_CH, joystick supply, constant 1.
REQ-009 SHALL have port o_gnd, output, N_CH, joystick ground, constant 0.
REQ-010 SHALL have port o_state, output, N_CH*N_BTN, debounced level, 1 = pressed.
REQ-011 SHALL have port o_evt_valid, output, 1, event available.
REQ-012 SHALL have port i_evt_ready, input, 1, consumer accepts event.
REQ-013 SHALL have port o_evt_ch, output, 3, and o_evt_btn, output, 3, identifying the event source.
REQ-014 SHALL have port o_evt_kind, output, 2: 0 press, 1 release, 2 repeat.
REQ-015 SHALL have port o_overflow, output, 1, sticky flag for a lost event.

Function
REQ-016 SHALL pass each raw bit through a 2-flop synchroniser, then invert it to form the active-high sample s.
REQ-017 SHALL give each button a counter: if s equals o_state, clear it; otherwise increment it, and when it reaches DEB_CYCLES-1, toggle o_state and clear the counter.
REQ-018 SHALL set o_state latency from a clean raw edge to DEB_CYCLES+2 cycles; a glitch shorter than DEB_CYCLES SHALL not change o_state.
REQ-019 SHALL, on each o_state toggle, set that button's pending bit with kind press (0->1) or release (1->0).
REQ-020 SHALL, if a button's pending bit is already set when a new event arrives, overwrite that button's kind and set o_overflow.
REQ-021 SHALL present the lowest-index pending button on o_evt_*, with o_evt_valid = OR of all pending bits.
REQ-022 SHALL hold the presented fields stable while o_evt_valid=1 and i_evt_ready=0.
REQ-023 SHALL clear the presented pending bit on a valid&&ready cycle; the next event SHALL appear the following cycle.
REQ-024 SHALL let a new event on the presented button in the same cycle as its handshake win: the bit stays set with the new kind, and o_overflow is not set.
REQ-025 SHALL clear o_overflow only on rst.

Reset
REQ-026 SHALL, on rst, clear synchronisers to released, and clear counters, o_state, pending bits, repeat timers, o_evt_valid, o_evt_ch, o_evt_btn, o_evt_kind and o_overflow.
REQ-027 SHALL discard in-progress debounce windows and undelivered events on rst asserted mid-operation.
REQ-028 SHALL suppress press events on the first cycle after reset for buttons already held; they SHALL debounce normally and generate a press DEB_CYCLES+2 cycles later.

Configuration
REQ-029 SHALL, with macro JOYSTICK_AUTO_REPEAT_EN defined, generate kind-2 repeat events for a held button REPEAT_DELAY cycles after its press and every REPEAT_PERIOD thereafter, restarting the timer on release.
REQ-030 SHALL, with JOYSTICK_AUTO_REPEAT_EN undefined, omit the repeat timers entirely and never emit kind 2.

Structure
REQ-031 SHALL place the event-kind enum (EVT_PRESS, EVT_RELEASE, EVT_REPEAT) and the button-index constants in the shared package joystick_pkg.
REQ-032 SHALL implement the per-button synchroniser and debouncer as sub-module btn_debounce, instantiated N_CH*N_BTN times.

Verification (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, N_CH=2)
REQ-033 SHALL cover: ch1 fire held low 10 cycles -> o_state[9]=1 exactly 6 cycles after the edge; one press event ch=1 btn=4 kind=0.
REQ-034 SHALL cover: 3-cycle low glitch on ch0 up -> o_state unchanged and no event.
REQ-035 SHALL cover: ch0 up and ch1 down pressed together, ready=1 -> ch0/btn0 delivered first, ch1/btn1 on the next cycle.
REQ-036 SHALL cover: ready=0 while a button is pressed then released -> single pending event of kind release, o_overflow=1.
REQ-037 SHALL cover: with JOYSTICK_AUTO_REPEAT_EN, hold ch0 left 40 cycles with ready=1 -> press, repeats at +20 and +28 cycles, then release.
REQ-038 SHALL cover: rst pulsed mid-window with a pending event -> all outputs 0 the next cycle, no stale event afterwards.

Source files
------------

// File: rtl/joystick_pkg.sv
// Shared types and constants for the joystick array.
// Event kinds as presented on o_evt_kind. Button indices within a channel.
package joystick_pkg;
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_kind_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE  = 4;
endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser + debouncer.
// Ports: clk, rst (sync, active-high), i_raw_n (raw active-low switch),
//        o_state (debounced level, 1 = pressed),
//        o_tgl (1 in the cycle whose clock edge toggles o_state).
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw_n,
  output logic o_state,
  output logic o_tgl
);
  import joystick_pkg::*;

  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_state;
  logic          w_s;

  assign w_s     = ~r_sync[1];
  assign o_state = r_state;
  // Sample has differed for DEB_CYCLES consecutive cycles, counting this one.
  assign o_tgl   = (w_s != r_state) && (r_cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;          // released
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw_n};
      if (w_s == r_state) begin
        r_cnt <= '0;
      end else if (o_tgl) begin
        r_cnt   <= '0;
        r_state <= ~r_state;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/joystick_array.sv
// Array of debounced joysticks with a single prioritised event stream.
// Optional feature: define JOYSTICK_AUTO_REPEAT_EN to add per-button
// auto-repeat (kind 2) events while a button is held.
// Ports: clk, rst (sync, active-high), i_btn_n (raw active-low switches,
//        bit ch*N_BTN+btn), o_vdd/o_gnd (joystick supply), o_state
//        (debounced, 1 = pressed), o_evt_valid/i_evt_ready handshake,
//        o_evt_ch/o_evt_btn/o_evt_kind event fields, o_overflow (sticky).
module joystick_array
  import joystick_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int N_BTN         = 5,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*N_BTN-1:0]  i_btn_n,
  output logic [N_CH-1:0]        o_vdd,
  output logic [N_CH-1:0]        o_gnd,
  output logic [N_CH*N_BTN-1:0]  o_state,
  output logic                   o_evt_valid,
  input  logic                   i_evt_ready,
  output logic [2:0]             o_evt_ch,
  output logic [2:0]             o_evt_btn,
  output logic [1:0]             o_evt_kind,
  output logic                   o_overflow
);
  localparam int NB = N_CH * N_BTN;
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;

  logic [NB-1:0]       w_tgl, w_rep, w_evt;
  logic [NB-1:0][1:0]  w_new_kind;

  assign o_vdd = '1;
  assign o_gnd = '0;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NB-1:0] (
    .clk     (clk),
    .rst     (rst),
    .i_raw_n (i_btn_n),
    .o_state (o_state),
    .o_tgl   (w_tgl)
  );

`ifdef JOYSTICK_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [NB-1:0][RW-1:0] r_rep_cnt;
  logic [NB-1:0]         r_rep_first;

  // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD; a toggle wins.
  always_comb begin
    w_rep = '0;
    for (int b = 0; b < NB; b++)
      w_rep[b] = o_state[b] && !w_tgl[b] &&
                 (r_rep_cnt[b] == (r_rep_first[b] ? RW'(REPEAT_DELAY - 1)
                                                  : RW'(REPEAT_PERIOD - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_first <= '1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_tgl[b] || !o_state[b]) begin
          r_rep_cnt[b]   <= '0;
          r_rep_first[b] <= 1'b1;
        end else if (w_rep[b]) begin
          r_rep_cnt[b]   <= '0;
          r_rep_first[b] <= 1'b0;
        end else begin
          r_rep_cnt[b] <= r_rep_cnt[b] + RW'(1);
        end
      end
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rep        = '0;
`endif

  assign w_evt = w_tgl | w_rep;

  always_comb begin
    w_new_kind = '0;
    for (int b = 0; b < NB; b++)
      w_new_kind[b] = w_tgl[b] ? (o_state[b] ? EVT_RELEASE : EVT_PRESS) : EVT_REPEAT;
  end

  logic [NB-1:0]       r_pend, w_pend_nxt;
  logic [NB-1:0][1:0]  r_kind, w_kind_nxt;
  logic                r_vld, w_vld_nxt, w_hs, w_ovf_set, r_ovf;
  logic [SW-1:0]       r_sel, w_sel_nxt;
  logic [2:0]          r_ch, r_btn, w_ch_nxt, w_btn_nxt;
  logic [1:0]          r_okind;

  always_comb begin
    w_hs       = r_vld && i_evt_ready;
    w_pend_nxt = r_pend;
    w_kind_nxt = r_kind;
    w_ovf_set  = 1'b0;
    // Clear the delivered bit first so a same-cycle new event on it is kept
    // without counting as an overflow.
    if (w_hs) w_pend_nxt[r_sel] = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (w_evt[b]) begin
        if (w_pend_nxt[b]) w_ovf_set = 1'b1;
        w_pend_nxt[b] = 1'b1;
        w_kind_nxt[b] = w_new_kind[b];
      end
    end
    // Presentation is locked while stalled; otherwise pick lowest pending.
    w_vld_nxt = r_vld;
    w_sel_nxt = r_sel;
    w_ch_nxt  = r_ch;
    w_btn_nxt = r_btn;
    if (!(r_vld && !i_evt_ready)) begin
      w_vld_nxt = |w_pend_nxt;
      w_sel_nxt = '0;
      w_ch_nxt  = '0;
      w_btn_nxt = '0;
      for (int b = NB - 1; b >= 0; b--) begin
        if (w_pend_nxt[b]) begin
          w_sel_nxt = SW'(b);
          w_ch_nxt  = 3'(b / N_BTN);
          w_btn_nxt = 3'(b % N_BTN);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_kind  <= '0;
      r_vld   <= 1'b0;
      r_sel   <= '0;
      r_ch    <= '0;
      r_btn   <= '0;
      r_okind <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_kind  <= w_kind_nxt;
      r_vld   <= w_vld_nxt;
      r_sel   <= w_sel_nxt;
      r_ch    <= w_ch_nxt;
      r_btn   <= w_btn_nxt;
      // Kind follows overwrites of the presented button even while stalled.
      r_okind <= w_kind_nxt[w_sel_nxt];
      r_ovf   <= r_ovf | w_ovf_set;
    end
  end

  assign o_evt_valid = r_vld;
  assign o_evt_ch    = r_ch;
  assign o_evt_btn   = r_btn;
  assign o_evt_kind  = r_okind;
  assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_joystick_array.sv
module tb_joystick_array;
  localparam int NCH = 2, NBT = 5, NB = NCH * NBT;
  localparam int DEB = 4, RD = 20, RP = 8;

  logic          clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [NB-1:0] btn_n = '1;
  logic [NCH-1:0] vdd, gnd;
  logic [NB-1:0] state;
  logic          evt_valid, ovf;
  logic [2:0]    evt_ch, evt_btn;
  logic [1:0]    evt_kind;

  joystick_array #(.N_CH(NCH), .N_BTN(NBT), .DEB_CYCLES(DEB),
                   .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .i_btn_n(btn_n), .o_vdd(vdd), .o_gnd(gnd),
    .o_state(state), .o_evt_valid(evt_valid), .i_evt_ready(ready),
    .o_evt_ch(evt_ch), .o_evt_btn(evt_btn), .o_evt_kind(evt_kind),
    .o_overflow(ovf));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model (runs on each clock edge) -------------
  int  cyc = 0;
  bit  mst [NB];          // expected debounced level
  bit  hist [NB][$];      // pressed-samples, newest last
  int  press_at [NB];
  int  expq [NB][$];      // undelivered expected kinds per button
  bit  exp_ovf = 0;

  task automatic push_evt(input int b, input int k);
    if (expq[b].size() != 0) exp_ovf = 1;
    expq[b].push_back(k);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_ovf = 0;
      for (int b = 0; b < NB; b++) begin
        mst[b] = 0;
        hist[b].delete();
        for (int k = 0; k < DEB + 2; k++) hist[b].push_back(1'b0);
        expq[b].delete();
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        bit all_diff;
        hist[b].push_back(!btn_n[b]);
        void'(hist[b].pop_front());
        // Level seen after 2-stage sync must differ for DEB cycles in a row.
        all_diff = 1;
        for (int k = 0; k < DEB; k++) if (hist[b][k] == mst[b]) all_diff = 0;
        if (all_diff) begin
          push_evt(b, mst[b] ? 1 : 0);
          mst[b] = !mst[b];
          press_at[b] = cyc;
        end
`ifdef JOYSTICK_AUTO_REPEAT_EN
        else if (mst[b]) begin
          int dt;
          dt = cyc - press_at[b];
          if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) push_evt(b, 2);
        end
`endif
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  int ndeliv = 0;
  int dlog_b[$], dlog_k[$], dlog_c[$];
  bit pv = 0, pr = 0, prst = 1;
  int pch = 0, pbtn = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [NB-1:0] es;
      for (int b = 0; b < NB; b++) es[b] = mst[b];
      chk("o_state", int'(state), int'(es));
      chk("o_overflow", int'(ovf), int'(exp_ovf));
      if (pv && !pr && !prst) begin
        chk("hold_ch", int'(evt_ch), pch);
        chk("hold_btn", int'(evt_btn), pbtn);
      end
      if (evt_valid && ready) begin
        int b, ek;
        b = int'(evt_ch) * NBT + int'(evt_btn);
        chk("evt_index_range", int'(b < NB), 1);
        if (b < NB) begin
          chk("evt_expected", int'(expq[b].size() > 0), 1);
          if (expq[b].size() > 0) begin
            ek = expq[b][$];
            expq[b].delete();
            chk("evt_kind", int'(evt_kind), ek);
          end
        end
        ndeliv++;
        dlog_b.push_back(b);
        dlog_k.push_back(int'(evt_kind));
        dlog_c.push_back(cyc);
      end
    end
    pv = evt_valid; pr = ready; prst = rst;
    pch = int'(evt_ch); pbtn = int'(evt_btn);
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    dlog_b.delete(); dlog_k.delete(); dlog_c.delete();
  endtask

  initial begin
    int d0;
    tick(3);
    @(negedge clk);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_fields", int'({evt_ch, evt_btn, evt_kind}), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("vdd", int'(vdd), 3);
    chk("gnd", int'(gnd), 0);
    tick(1);
    rst = 0; ready = 1;
    tick(2);

    // ch1 fire: exact latency and single press
    clr_log(); d0 = ndeliv;
    btn_n[9] = 0;
    tick(5); @(negedge clk);
    chk("fire_lat5", int'(state[9]), 0);
    tick(1); @(negedge clk);
    chk("fire_lat6", int'(state[9]), 1);
    tick(4); @(negedge clk);
    chk("fire_nevt", ndeliv - d0, 1);
    if (dlog_b.size() > 0) begin
      chk("fire_idx", dlog_b[0], 9);
      chk("fire_kind", dlog_k[0], 0);
    end
    tick(1);
    btn_n[9] = 1;
    tick(12);

    // 3-cycle glitch
    d0 = ndeliv;
    btn_n[0] = 0; tick(3); btn_n[0] = 1; tick(10);
    @(negedge clk);
    chk("glitch_state", int'(state[0]), 0);
    chk("glitch_nevt", ndeliv - d0, 0);
    tick(1);

    // simultaneous presses: lowest index first, next on following cycle
    clr_log();
    btn_n[0] = 0; btn_n[6] = 0; tick(10);
    chk("prio_cnt", int'(dlog_b.size() >= 2), 1);
    if (dlog_b.size() >= 2) begin
      chk("prio_first", dlog_b[0], 0);
      chk("prio_second", dlog_b[1], 6);
      chk("prio_gap", dlog_c[1] - dlog_c[0], 1);
    end
    btn_n[0] = 1; btn_n[6] = 1; tick(12);

    // stalled press then release -> one release event, overflow
    ready = 0;
    btn_n[2] = 0; tick(8); btn_n[2] = 1; tick(8);
    @(negedge clk);
    chk("ovf_valid", int'(evt_valid), 1);
    chk("ovf_btn", int'(evt_btn), 2);
    chk("ovf_kind", int'(evt_kind), 1);
    chk("ovf_flag", int'(ovf), 1);
    tick(1);
    d0 = ndeliv; ready = 1; tick(4);
    chk("ovf_single", ndeliv - d0, 1);

`ifdef JOYSTICK_AUTO_REPEAT_EN
    clr_log();
    btn_n[2] = 0; tick(40); btn_n[2] = 1; tick(12);
    chk("rep_cnt", int'(dlog_k.size() >= 4), 1);
    if (dlog_k.size() >= 4) begin
      chk("rep_press", dlog_k[0], 0);
      chk("rep_k1", dlog_k[1], 2);
      chk("rep_t1", dlog_c[1] - dlog_c[0], RD);
      chk("rep_k2", dlog_k[2], 2);
      chk("rep_t2", dlog_c[2] - dlog_c[0], RD + RP);
      chk("rep_release", dlog_k[dlog_k.size()-1], 1);
    end
`endif

    // reset mid-operation with a pending event and an open window
    ready = 0;
    btn_n[3] = 0; tick(8);
    btn_n[4] = 0; tick(2);
    rst = 1; btn_n = '1;
    tick(1);
    rst = 0;
    @(negedge clk);
    chk("mrst_valid", int'(evt_valid), 0);
    chk("mrst_fields", int'({evt_ch, evt_btn, evt_kind}), 0);
    chk("mrst_state", int'(state), 0);
    chk("mrst_ovf", int'(ovf), 0);
    tick(1);
    d0 = ndeliv; ready = 1; tick(20);
    chk("mrst_stale", ndeliv - d0, 0);

    // randomized traffic with random back-pressure
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(7) == 0) btn_n[b] = ~btn_n[b];
      ready = ($urandom_range(3) != 0);
      tick(1);
    end
    btn_n = '1; ready = 1;
    tick(60);
    for (int b = 0; b < NB; b++) chk("drain_empty", expq[b].size(), 0);
    @(negedge clk);
    chk("drain_valid", int'(evt_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
